// File: rtl/ca_cmd_if.sv
// Command/status bundle for ca_rule_engine: op request handshake, rule masks, and completion status.
interface ca_cmd_if #(
  parameter int LOG_W = 6,
  parameter int LOG_H = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LOG_W-1:0] cmd_x;
  logic [LOG_H-1:0] cmd_y;
  logic             cmd_val;
  logic [8:0]       birth_mask;
  logic [8:0]       survive_mask;
  logic             wrap_en;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_val, birth_mask, survive_mask, wrap_en,
    input  cmd_ready, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_val, birth_mask, survive_mask, wrap_en,
    output cmd_ready, busy, done
  );
endinterface

// File: rtl/ca_rule_engine.sv
// Life-like cellular automaton core: double-buffered board, per-command B/S rule, SET/RANDOMIZE/CLEAR.
// Optional live-cell counter enabled by defining CA_POPCOUNT_EN.
module ca_rule_engine #(
  parameter int          LOG_W     = 6,
  parameter int          LOG_H     = 5,
  parameter int          GEN_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'h0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ca_cmd_if.slave                cmd,
  output logic [GEN_W-1:0]       generation,
  input  logic [LOG_W-1:0]       rd_x,
  input  logic [LOG_H-1:0]       rd_y,
  output logic                   rd_alive,
  output logic [LOG_W+LOG_H:0]   population
);
  localparam int AW = LOG_W + LOG_H;
  localparam int N  = 1 << AW;
  localparam int PW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UPDATE = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_SWAP   = 3'd3;
  localparam logic [2:0] S_SET    = 3'd4;

  localparam logic [1:0] OP_STEP = 2'd0;
  localparam logic [1:0] OP_RND  = 2'd1;
  localparam logic [1:0] OP_CLR  = 2'd2;

  logic [2:0]       state;
  logic [N-1:0]     bank0, bank1, front;
  logic             bank;
  logic [AW-1:0]    cnt;
  logic [3:0]       phase, nacc;
  logic             is_rnd, is_step;
  logic [8:0]       bmask, smask;
  logic             wrap;
  logic [LOG_W-1:0] sx;
  logic [LOG_H-1:0] sy;
  logic             sval;
  logic [15:0]      lfsr;

  logic             accept;
  logic             xm, xp, ym, yp, off, nbit;
  logic [LOG_W-1:0] cx, nx;
  logic [LOG_H-1:0] cy, ny;
  logic             back_we, back_val, new_cell;

  assign front         = bank ? bank1 : bank0;
  assign cmd.cmd_ready = (state == S_IDLE);
  assign cmd.busy      = (state != S_IDLE);
  assign cmd.done      = (state == S_SWAP) || (state == S_SET);
  assign accept        = cmd.cmd_valid && (state == S_IDLE);

  // Neighbour offset for the current accumulate phase
  always_comb begin
    xm = 1'b0; xp = 1'b0; ym = 1'b0; yp = 1'b0;
    case (phase[2:0])
      3'd0:    begin xm = 1'b1; yp = 1'b1; end
      3'd1:    yp = 1'b1;
      3'd2:    begin xp = 1'b1; yp = 1'b1; end
      3'd3:    xm = 1'b1;
      3'd4:    xp = 1'b1;
      3'd5:    begin xm = 1'b1; ym = 1'b1; end
      3'd6:    ym = 1'b1;
      default: begin xp = 1'b1; ym = 1'b1; end
    endcase
  end

  assign cx  = cnt[LOG_W-1:0];
  assign cy  = cnt[AW-1:LOG_W];
  assign nx  = xp ? cx + LOG_W'(1) : (xm ? cx - LOG_W'(1) : cx);
  assign ny  = yp ? cy + LOG_H'(1) : (ym ? cy - LOG_H'(1) : cy);
  // Coordinates wrap naturally in LOG_W/LOG_H bits; dead-edge mode masks the wrapped reads
  assign off = (xm && cx == '0) || (xp && cx == '1) || (ym && cy == '0) || (yp && cy == '1);
  assign nbit = front[{ny, nx}] & (wrap | ~off);
  assign new_cell = front[cnt] ? smask[nacc] : bmask[nacc];

  always_comb begin
    back_we  = 1'b0;
    back_val = 1'b0;
    if (state == S_UPDATE && phase == 4'd8) begin
      back_we  = 1'b1;
      back_val = new_cell;
    end else if (state == S_INIT) begin
      back_we  = 1'b1;
      back_val = is_rnd & lfsr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Board storage is never reset: the CLEAR that follows reset overwrites the bank that becomes front
  always_ff @(posedge clk) begin
    if (back_we) begin
      if (bank) bank0[cnt] <= back_val;
      else      bank1[cnt] <= back_val;
    end else if (state == S_SET) begin
      if (bank) bank1[{sy, sx}] <= sval;
      else      bank0[{sy, sx}] <= sval;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_INIT;
      is_rnd     <= 1'b0;
      is_step    <= 1'b0;
      cnt        <= '0;
      phase      <= '0;
      nacc       <= '0;
      bank       <= 1'b0;
      generation <= '0;
      rd_alive   <= 1'b0;
      bmask      <= '0;
      smask      <= '0;
      wrap       <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      sval       <= 1'b0;
    end else begin
      rd_alive <= front[{rd_y, rd_x}];
      case (state)
        S_IDLE: if (accept) begin
          bmask   <= cmd.birth_mask;
          smask   <= cmd.survive_mask;
          wrap    <= cmd.wrap_en;
          sx      <= cmd.cmd_x;
          sy      <= cmd.cmd_y;
          sval    <= cmd.cmd_val;
          cnt     <= '0;
          phase   <= '0;
          nacc    <= '0;
          is_step <= (cmd.cmd_op == OP_STEP);
          is_rnd  <= (cmd.cmd_op == OP_RND);
          case (cmd.cmd_op)
            OP_STEP: state <= S_UPDATE;
            OP_RND,
            OP_CLR:  state <= S_INIT;
            default: state <= S_SET;
          endcase
        end
        S_UPDATE: begin
          if (phase == 4'd8) begin
            phase <= '0;
            nacc  <= '0;
            cnt   <= cnt + AW'(1);
            if (cnt == '1) state <= S_SWAP;
          end else begin
            phase <= phase + 4'd1;
            nacc  <= nacc + {3'b000, nbit};
          end
        end
        S_INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == '1) state <= S_SWAP;
        end
        S_SWAP: begin
          bank       <= ~bank;
          generation <= is_step ? generation + GEN_W'(1) : '0;
          state      <= S_IDLE;
        end
        S_SET:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CA_POPCOUNT_EN
  logic [PW-1:0] pop_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_acc    <= '0;
      population <= '0;
    end else begin
      if (accept)                  pop_acc <= '0;
      else if (back_we && back_val) pop_acc <= pop_acc + PW'(1);
      if (state == S_SWAP)
        population <= pop_acc;
      else if (state == S_SET && front[{sy, sx}] != sval)
        population <= sval ? population + PW'(1) : population - PW'(1);
    end
  end
`else
  assign population = '0;
`endif
endmodule

// File: tb/tb_ca_rule_engine.sv
// Self-checking bench for ca_rule_engine on an 8x8 board: reset, SET table, rule corners, random vs model.
module tb_ca_rule_engine;
  localparam int LW = 3, LH = 3, W = 8, H = 8, N = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] generation;
  logic [2:0]  rd_x = '0, rd_y = '0;
  logic        rd_alive;
  logic [6:0]  population;

  always #5 clk = ~clk;

  ca_cmd_if #(.LOG_W(LW), .LOG_H(LH)) cif();

  ca_rule_engine #(.LOG_W(LW), .LOG_H(LH), .GEN_W(16), .LFSR_SEED(16'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif), .generation(generation),
    .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive), .population(population)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l = 16'h0001;
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  function automatic logic [63:0] life(input logic [63:0] b, input logic [8:0] bm,
                                       input logic [8:0] sm, input bit wrap);
    logic [63:0] r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx = x + dx;
            int ny = y + dy;
            if (dx == 0 && dy == 0) continue;
            if (wrap) n += b[((ny + H) % H) * W + (nx + W) % W];
            else if (nx >= 0 && nx < W && ny >= 0 && ny < H) n += b[ny * W + nx];
          end
        r[y * W + x] = b[y * W + x] ? sm[n] : bm[n];
      end
    return r;
  endfunction

  function automatic int exp_pop(input int c);
`ifdef CA_POPCOUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic int idx(input int x, input int y);
    return y * W + x;
  endfunction

  task automatic read_board(output logic [63:0] b);
    b = '0;
    for (int i = 0; i < N; i++) begin
      rd_x = 3'(i % W);
      rd_y = 3'(i / W);
      tick();
      b[i] = rd_alive;
    end
  endtask

  // Waits for ready, issues one command, returns done latency (cycles after accept) and cyc of cycle T+1
  task automatic issue(input logic [1:0] op, input int x, input int y, input logic v,
                       input logic [8:0] bm, input logic [8:0] sm, input logic wr,
                       input bit noise, output int lat, output int c_first);
    int g = 0;
    while (!cif.cmd_ready && g < 2000) begin tick(); g++; end
    if (!cif.cmd_ready) check("ready_timeout", 0, 1);
    cif.cmd_op = op; cif.cmd_x = 3'(x); cif.cmd_y = 3'(y); cif.cmd_val = v;
    cif.birth_mask = bm; cif.survive_mask = sm; cif.wrap_en = wr;
    cif.cmd_valid = 1'b1;
    tick();
    cif.cmd_valid = 1'b0;
    c_first = cyc;
    lat = 1;
    while (!cif.done && lat < 1000) begin
      if (noise) begin cif.cmd_valid = 1'($urandom % 2); cif.cmd_op = 2'd2; end
      tick();
      lat++;
    end
    cif.cmd_valid = 1'b0;
    if (!cif.done) check("done_timeout", 0, 1);
  endtask

  // Called in the first cycle after rst_n returns high: expects a 65-cycle CLEAR with one done at its end
  task automatic check_clear_after_reset(input string tag);
    int bc = 0, dn = 0, dpos = 0;
    logic [63:0] b;
    while (cif.busy && bc < 500) begin
      bc++;
      if (cif.done) begin dn++; dpos = bc; end
      tick();
    end
    check({tag, "_busy_cycles"}, bc, 65);
    check({tag, "_done_count"}, dn, 1);
    check({tag, "_done_pos"}, dpos, 65);
    check({tag, "_ready"}, cif.cmd_ready, 1);
    check({tag, "_gen"}, generation, 0);
    read_board(b);
    check({tag, "_board"}, b, 64'h0);
    check({tag, "_pop"}, population, 0);
  endtask

  typedef struct {
    int       x, y;
    logic     v;
    logic     alive;
    int       pop;
  } set_vec_t;

  localparam logic [8:0] B3 = 9'h008, S23 = 9'h00C;

  initial begin
    set_vec_t    sv[7];
    logic [63:0] b, e, mdl;
    int          lat, c0;
    logic [8:0]  bm, sm;
    logic        wr;
    logic [15:0] l;

    sv[0] = '{3, 2, 1'b1, 1'b1, 1};
    sv[1] = '{3, 3, 1'b1, 1'b1, 2};
    sv[2] = '{3, 4, 1'b1, 1'b1, 3};
    sv[3] = '{3, 3, 1'b1, 1'b1, 3};
    sv[4] = '{5, 5, 1'b0, 1'b0, 3};
    sv[5] = '{5, 5, 1'b1, 1'b1, 4};
    sv[6] = '{5, 5, 1'b0, 1'b0, 3};

    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_x = '0; cif.cmd_y = '0; cif.cmd_val = 1'b0;
    cif.birth_mask = '0; cif.survive_mask = '0; cif.wrap_en = 1'b0;

    // Reset values, then the post-reset CLEAR
    tick(); tick();
    check("rst_ready", cif.cmd_ready, 0);
    check("rst_busy", cif.busy, 1);
    check("rst_done", cif.done, 0);
    check("rst_gen", generation, 0);
    check("rst_rd_alive", rd_alive, 0);
    check("rst_pop", population, 0);
    rst_n = 1'b1;
    check_clear_after_reset("t1");

    // SET table, builds a vertical blinker at x=3
    foreach (sv[i]) begin
      issue(2'd3, sv[i].x, sv[i].y, sv[i].v, B3, S23, 1'b1, 1'b0, lat, c0);
      check("set_lat", lat, 1);
      rd_x = 3'(sv[i].x); rd_y = 3'(sv[i].y);
      tick(); tick();
      check("set_alive", rd_alive, sv[i].alive);
      check("set_pop", population, exp_pop(sv[i].pop));
      check("set_gen", generation, 0);
    end

    issue(2'd0, 0, 0, 1'b0, B3, S23, 1'b1, 1'b0, lat, c0);
    check("t2_step_lat", lat, 577);
    tick();
    check("t2_gen", generation, 1);
    check("t2_pop", population, exp_pop(3));
    read_board(b);
    e = '0; e[idx(2, 3)] = 1'b1; e[idx(3, 3)] = 1'b1; e[idx(4, 3)] = 1'b1;
    check("t2_board", b, e);

    // Blinker straddling the x edge, toroidal then dead-edge
    for (int m = 1; m >= 0; m--) begin
      issue(2'd2, 0, 0, 1'b0, B3, S23, 1'b0, 1'b0, lat, c0);
      check("clr_lat", lat, 65);
      issue(2'd3, 7, 3, 1'b1, B3, S23, 1'b0, 1'b0, lat, c0);
      issue(2'd3, 0, 3, 1'b1, B3, S23, 1'b0, 1'b0, lat, c0);
      issue(2'd3, 1, 3, 1'b1, B3, S23, 1'b0, 1'b0, lat, c0);
      issue(2'd0, 0, 0, 1'b0, B3, S23, 1'(m), 1'b0, lat, c0);
      tick();
      read_board(b);
      e = '0;
      if (m == 1) begin e[idx(0, 2)] = 1'b1; e[idx(0, 3)] = 1'b1; e[idx(0, 4)] = 1'b1; end
      check(m == 1 ? "t3_wrap_board" : "t3_dead_board", b, e);
      check("t3_pop", population, exp_pop(m == 1 ? 3 : 0));
      check("t3_gen", generation, 1);
    end

    // B1/S- from a single cell gives the 8-cell ring
    issue(2'd2, 0, 0, 1'b0, B3, S23, 1'b0, 1'b0, lat, c0);
    issue(2'd3, 4, 4, 1'b1, B3, S23, 1'b0, 1'b0, lat, c0);
    issue(2'd0, 0, 0, 1'b0, 9'h002, 9'h000, 1'b1, 1'b0, lat, c0);
    tick();
    read_board(b);
    e = '0;
    for (int y = 3; y <= 5; y++) for (int x = 3; x <= 5; x++) if (!(x == 4 && y == 4)) e[idx(x, y)] = 1'b1;
    check("t4_board", b, e);
    check("t4_pop", population, exp_pop(8));

    // RANDOMIZE after reset with dropped requests while busy
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_clear_after_reset("t5rst");
    issue(2'd1, 0, 0, 1'b0, B3, S23, 1'b1, 1'b1, lat, c0);
    check("t5_rnd_lat", lat, 65);
    mdl = '0;
    for (int i = 0; i < N; i++) begin l = lfsr_at(c0 + i); mdl[i] = l[0]; end
    tick(); tick(); tick();
    check("t5_busy_dropped", cif.busy, 0);
    check("t5_gen", generation, 0);
    check("t5_pop", population, exp_pop($countones(mdl)));
    read_board(b);
    check("t5_board", b, mdl);

    // Random rules, wrap and SETs against the behavioural model
    for (int r = 0; r < 6; r++) begin
      bm = 9'($urandom); sm = 9'($urandom); wr = 1'($urandom % 2);
      for (int k = 0; k < 3; k++) begin
        int x = $urandom % W, y = $urandom % H;
        logic v = 1'($urandom % 2);
        issue(2'd3, x, y, v, bm, sm, wr, 1'b0, lat, c0);
        mdl[idx(x, y)] = v;
      end
      issue(2'd0, 0, 0, 1'b0, bm, sm, wr, 1'b0, lat, c0);
      mdl = life(mdl, bm, sm, wr);
      tick();
      check("rnd_gen", generation, 16'(r + 1));
      check("rnd_pop", population, exp_pop($countones(mdl)));
      read_board(b);
      check("rnd_board", b, mdl);
    end

    // Reset pulse in the middle of UPDATE
    cif.cmd_op = 2'd0; cif.birth_mask = B3; cif.survive_mask = S23; cif.wrap_en = 1'b1;
    cif.cmd_valid = 1'b1; tick(); cif.cmd_valid = 1'b0;
    repeat (100) tick();
    check("t6_mid_busy", cif.busy, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_clear_after_reset("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
